// File: rtl/triangle_rasterizer.sv
// Triangle rasterizer: walks the screen-clamped bounding box of one triangle
// per pass, tests every pixel centre against the three edge functions and
// emits a fragment with barycentric weights for each covered pixel.
`timescale 1ns/1ps

package triangle_rasterizer_pkg;
    // Q20.20 fixed point: wide enough for products of full-screen edge
    // lengths and fine enough for the reciprocal of a full-screen area.
    localparam int DATA_W = 40;
    localparam int FRAC_W = 20;

    typedef logic signed [DATA_W-1:0] fixed_t;

    typedef struct packed {
        fixed_t x;
        fixed_t y;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
        fixed_t  area_inv;
    } attributed_triangle_t;

    typedef logic [15:0] triangle_metadata_t;
endpackage

module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    output logic                                   attributed_triangle_s_ready,
    input  logic                                   attributed_triangle_s_valid,
    input  logic [$bits(attributed_triangle_t)-1:0] attributed_triangle_s_data,
    input  logic [$bits(triangle_metadata_t)-1:0]  attributed_triangle_s_metadata,
    input  logic                                   fragment_m_ready,
    output logic                                   fragment_m_valid,
    output logic [$clog2(SCREEN_WIDTH)-1:0]        fragment_m_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0]       fragment_m_y,
    output logic [DATA_W-1:0]                      fragment_m_w0,
    output logic [DATA_W-1:0]                      fragment_m_w1,
    output logic [DATA_W-1:0]                      fragment_m_w2,
    output logic [$bits(triangle_metadata_t)-1:0]  fragment_m_metadata,
    output logic                                   triangle_done
);
    localparam int XW = $clog2(SCREEN_WIDTH);
    localparam int YW = $clog2(SCREEN_HEIGHT);
    localparam fixed_t X_LAST = fixed_t'(SCREEN_WIDTH - 1);
    localparam fixed_t Y_LAST = fixed_t'(SCREEN_HEIGHT - 1);
    localparam logic signed [2*DATA_W-1:0] WIDE_MAX = {{DATA_W{1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] WIDE_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, FINISH} state_t;

    function automatic logic signed [2*DATA_W-1:0] fx_ext(input fixed_t a);
        return {{DATA_W{a[DATA_W-1]}}, a};
    endfunction

    function automatic fixed_t fx_sat(input logic signed [2*DATA_W-1:0] v);
        if (v > WIDE_MAX) return fixed_t'(WIDE_MAX[DATA_W-1:0]);
        if (v < WIDE_MIN) return fixed_t'(WIDE_MIN[DATA_W-1:0]);
        return fixed_t'(v[DATA_W-1:0]);
    endfunction

    function automatic fixed_t fx_sub(input fixed_t a, input fixed_t b);
        return fx_sat(fx_ext(a) - fx_ext(b));
    endfunction

    // Product truncated toward minus infinity, then saturated.
    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic signed [2*DATA_W-1:0] p;
        p = fx_ext(a) * fx_ext(b);
        return fx_sat(p >>> FRAC_W);
    endfunction

    function automatic fixed_t fx_floor(input fixed_t a);
        return a >>> FRAC_W;
    endfunction

    function automatic fixed_t fx_min3(input fixed_t a, input fixed_t b, input fixed_t c);
        fixed_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic fixed_t fx_max3(input fixed_t a, input fixed_t b, input fixed_t c);
        fixed_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic fixed_t edge_fn(input vertex_t a, input vertex_t b, input fixed_t px, input fixed_t py);
        return fx_sub(fx_mul(fx_sub(b.x, a.x), fx_sub(py, a.y)),
                      fx_mul(fx_sub(b.y, a.y), fx_sub(px, a.x)));
    endfunction

    state_t               state_q, state_d;
    attributed_triangle_t tri_q;
    triangle_metadata_t   meta_q;
    logic [XW-1:0]        x_q, xmin_q, xmax_q;
    logic [YW-1:0]        y_q, ymax_q;

    fixed_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic   discard;
    fixed_t px, py, w0, w1, w2;
    logic   covered, load_ok, last_px;
    logic   capture, box_load, load, step;

    assign attributed_triangle_s_ready = (state_q == IDLE);
    assign triangle_done               = (state_q == FINISH);

    // Screen-clamped bounding box of the captured triangle and the discard test.
    always_comb begin
        bb_xmin = fx_floor(fx_min3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x));
        bb_xmax = fx_floor(fx_max3(tri_q.v0.x, tri_q.v1.x, tri_q.v2.x));
        bb_ymin = fx_floor(fx_min3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y));
        bb_ymax = fx_floor(fx_max3(tri_q.v0.y, tri_q.v1.y, tri_q.v2.y));
        if (bb_xmin < 0)      bb_xmin = '0;
        if (bb_ymin < 0)      bb_ymin = '0;
        if (bb_xmax > X_LAST) bb_xmax = X_LAST;
        if (bb_ymax > Y_LAST) bb_ymax = Y_LAST;
        discard = (tri_q.area_inv == '0) || (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
    end

    // Edge functions at the current pixel centre, scaled into barycentric weights.
    always_comb begin
        px      = $signed({{(DATA_W-FRAC_W-XW){1'b0}}, x_q, 1'b1, {(FRAC_W-1){1'b0}}});
        py      = $signed({{(DATA_W-FRAC_W-YW){1'b0}}, y_q, 1'b1, {(FRAC_W-1){1'b0}}});
        w0      = fx_mul(edge_fn(tri_q.v1, tri_q.v2, px, py), tri_q.area_inv);
        w1      = fx_mul(edge_fn(tri_q.v2, tri_q.v0, px, py), tri_q.area_inv);
        w2      = fx_mul(edge_fn(tri_q.v0, tri_q.v1, px, py), tri_q.area_inv);
        covered = !w0[DATA_W-1] && !w1[DATA_W-1] && !w2[DATA_W-1];
        load_ok = !fragment_m_valid || fragment_m_ready;
        last_px = (x_q == xmax_q) && (y_q == ymax_q);
    end

    // Next-state and per-cycle strobes; a covered pixel only advances once it is loaded.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        box_load = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (attributed_triangle_s_valid) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (discard) begin
                    state_d = FINISH;
                end else begin
                    box_load = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                load = covered && load_ok;
                if (!covered || load_ok) begin
                    if (last_px) state_d = FINISH;
                    else         step    = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Triangle capture, bounding box and row-major pixel walk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tri_q  <= '0;
            meta_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            xmin_q <= '0;
            xmax_q <= '0;
            ymax_q <= '0;
        end else begin
            if (capture) begin
                tri_q  <= attributed_triangle_s_data;
                meta_q <= attributed_triangle_s_metadata;
            end
            if (box_load) begin
                xmin_q <= bb_xmin[XW-1:0];
                xmax_q <= bb_xmax[XW-1:0];
                ymax_q <= bb_ymax[YW-1:0];
                x_q    <= bb_xmin[XW-1:0];
                y_q    <= bb_ymin[YW-1:0];
            end else if (step) begin
                if (x_q == xmax_q) begin
                    x_q <= xmin_q;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    // Fragment output register: holds until accepted, reloads only when free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fragment_m_valid    <= 1'b0;
            fragment_m_x        <= '0;
            fragment_m_y        <= '0;
            fragment_m_w0       <= '0;
            fragment_m_w1       <= '0;
            fragment_m_w2       <= '0;
            fragment_m_metadata <= '0;
        end else if (load) begin
            fragment_m_valid    <= 1'b1;
            fragment_m_x        <= x_q;
            fragment_m_y        <= y_q;
            fragment_m_w0       <= w0;
            fragment_m_w1       <= w1;
            fragment_m_w2       <= w2;
            fragment_m_metadata <= meta_q;
        end else if (fragment_m_ready) begin
            fragment_m_valid    <= 1'b0;
        end
    end
endmodule

// File: doc/triangle_rasterizer.md
Name: triangle_rasterizer

Overview:
- Consumes attributed triangles (three vertices plus the reciprocal of the signed doubled area, `area_inv`) from the triangle preprocessing stage.
- Walks the screen-clamped bounding box in row-major order and tests each pixel centre against the three edge functions.
- For every covered pixel it emits a fragment: pixel coordinates, barycentric weights w0/w1/w2 and the triangle metadata.
- Feeds the fragment shading / depth stage.

Parameters:
- SCREEN_WIDTH, 160, pixel columns; x range is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 120, pixel rows; y range is 0..SCREEN_HEIGHT-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- attributed_triangle_s_ready  out  1  ready for a new triangle.
- attributed_triangle_s_valid  in  1  input triangle valid.
- attributed_triangle_s_data  in  $bits(attributed_triangle_t)  triangle v0..v2 positions (fixed) plus area_inv (fixed).
- attributed_triangle_s_metadata  in  $bits(triangle_metadata_t)  per-triangle metadata.
- fragment_m_ready  in  1  downstream ready.
- fragment_m_valid  out  1  fragment valid.
- fragment_m_x  out  $clog2(SCREEN_WIDTH)  pixel column.
- fragment_m_y  out  $clog2(SCREEN_HEIGHT)  pixel row.
- fragment_m_w0, fragment_m_w1, fragment_m_w2  out  fixed width each  barycentric weights.
- fragment_m_metadata  out  $bits(triangle_metadata_t)  metadata of the owning triangle.
- triangle_done  out  1  one-cycle pulse when a triangle is fully rasterized or discarded.

Behaviour:
- Reset values:
  - state = IDLE.
  - attributed_triangle_s_ready = 1 (combinational from IDLE).
  - fragment_m_valid = 0.
  - All fragment data = 0.
  - triangle_done = 0.
  - Internal triangle and counter registers = 0.
- State machine, four states:
  - IDLE: s_ready = 1. On s_valid && s_ready, capture the triangle and metadata, then go to SETUP.
  - SETUP (1 cycle): compute the bounding box.
    - xmin = max(0, floor(min vx)), xmax = min(SCREEN_WIDTH-1, floor(max vx)); y likewise.
    - If area_inv == 0, or xmin > xmax, or ymin > ymax: go to FINISH with no fragments.
    - Otherwise load x = xmin, y = ymin and go to SCAN.
  - SCAN: evaluate one pixel per cycle (see coverage test and advance rule below).
  - FINISH (1 cycle): triangle_done = 1, then go to IDLE.
- Edge functions, with E(a,b,p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x):
  - p = (itof(x)+0.5, itof(y)+0.5), the pixel centre.
  - w0 = E(v1,v2,p)*area_inv, w1 = E(v2,v0,p)*area_inv, w2 = E(v0,v1,p)*area_inv.
  - All arithmetic uses the project fixed add/sub/mul with its saturation/truncation rules.
- Coverage: the pixel is covered iff w0 >= 0, w1 >= 0 and w2 >= 0.
  - Both windings are accepted, because area_inv carries the sign.
  - Edges are inclusive.
- Output register / advance rule:
  - The output register can load when !fragment_m_valid || fragment_m_ready.
  - Covered pixel with loadable register: load the fragment and advance.
  - Covered pixel with a stalled register: hold x/y and do not advance.
  - Uncovered pixel: advance regardless of backpressure.
  - Sustained rate is one pixel per cycle with no downstream stall.
- Advance order:
  - x++ until xmax; then x = xmin and y++.
  - After (xmax, ymax) go to FINISH, but only once the last fragment has been loaded into the output register.
- Output handshake:
  - fragment_m_valid stays high and the data stays stable until fragment_m_ready.
  - Valid may remain pending while in FINISH/IDLE; the next triangle's fragments must not overwrite an unaccepted fragment.
- The next triangle may be accepted in IDLE while the final fragment of the previous one is still pending.
- Latency: first fragment valid no earlier than 3 cycles after the accepting edge (IDLE→SETUP→SCAN→registered output).
- Asynchronous reset mid-scan: return to IDLE immediately, drop fragment_m_valid, and lose the in-flight triangle.

Test Plan:
- Basic coverage: v0=(0,0), v1=(4,0), v2=(0,4), area_inv=1/16, always ready.
  - Exactly 10 fragments, all with x+y <= 3, in row-major order.
  - First fragment (0,0) with w0=0.75, w1=0.125, w2=0.125.
  - Last fragment (0,3).
  - triangle_done pulses once.
- Reversed winding: same triangle with v1 and v2 swapped, area_inv=-1/16.
  - Same 10 pixels.
  - Weights permuted accordingly, each weight triple sums to 1.0.
- Backpressure: basic triangle with fragment_m_ready toggled randomly (50%).
  - Same 10 fragments, in order, none duplicated or lost.
  - Data stable while valid && !ready.
- Discard cases, each giving zero fragments, triangle_done 2 cycles after acceptance, and s_ready back to 1:
  - Degenerate triangle (0,0),(2,2),(4,4) with area_inv=0.
  - Off-screen triangle (200,10),(220,10),(200,30).
- Clamping: (-10,-10),(300,0),(0,300).
  - First fragment (0,0), last (159,119).
  - No fragment has x > 159 or y > 119.
- Reset mid-scan: assert rstn low during SCAN of the basic triangle.
  - Outputs return to reset values asynchronously.
  - A triangle accepted after release rasterizes correctly.
